// File: rtl/hazard_sequencer.sv
// Hazard and halt sequencer for the 5-stage core: load-use stalls, redirect
// flushes, HALT drain, and saturating stall/flush event counters.
module hazard_sequencer #(
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs2,
   input  logic             id_halt,
   input  logic             ex_memread,
   input  logic [4:0]       ex_rd,
   input  logic             ex_redirect,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   if (DRAIN_CYCLES == 0) begin : g_bad_drain
      $fatal(1, "hazard_sequencer: DRAIN_CYCLES must be at least 1");
   end

   localparam int unsigned     DrainW    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DrainW-1:0] DrainLoad = DrainW'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CntMax    = '1;

   typedef enum logic [1:0] {
      StRun,
      StDrain,
      StHalted
   } state_e;

   state_e            state_q, state_d;
   logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic              lu;

   // Load-use hazard: EX load writes a register the ID instruction reads; x0 is exempt.
   assign lu = ex_memread && (ex_rd != 5'd0) &&
               ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

   // Next-state, counter updates and combinational pipeline controls.
   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;

      unique case (state_q)
         StRun: begin
            if (ex_redirect) begin
               // ID holds a wrong-path instruction, so its hazards and HALT are moot.
               pc_write   = 1'b1;
               ifid_write = 1'b1;
               if (flush_cnt_q != CntMax) flush_cnt_d = flush_cnt_q + 1'b1;
            end else if (lu) begin
               ifid_flush = 1'b0;
               if (stall_cnt_q != CntMax) stall_cnt_d = stall_cnt_q + 1'b1;
            end else if (id_halt) begin
               // Freeze fetch but let HALT move on into EX.
               ifid_flush = 1'b0;
               idex_flush = 1'b0;
               if (DRAIN_CYCLES == 1) begin
                  state_d = StHalted;
               end else begin
                  state_d     = StDrain;
                  drain_cnt_d = DrainLoad;
               end
            end else begin
               pc_write   = 1'b1;
               ifid_write = 1'b1;
               ifid_flush = 1'b0;
               idex_flush = 1'b0;
            end
         end
         StDrain: begin
            // Leave on the cycle whose decrement reaches zero so halted lands
            // exactly DRAIN_CYCLES cycles after HALT was accepted.
            drain_cnt_d = drain_cnt_q - 1'b1;
            if (drain_cnt_q == DrainW'(1)) state_d = StHalted;
         end
         StHalted: begin
            state_d = StHalted;
         end
         default: begin
            state_d = StRun;
         end
      endcase

      // Hold the pipeline quiet while reset is asserted.
      if (!reset) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end
   end

   // State and counter registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StRun;
         drain_cnt_q <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign halted    = (state_q == StHalted);
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed scenarios followed by
// random stimulus, all checked against a cycle-indexed behavioural model.
module tb_hazard_sequencer;

   localparam int unsigned DrainCycles = 3;
   localparam int unsigned CntW        = 2;
   localparam int          CntMax      = (1 << CntW) - 1;

   logic            clk = 1'b0;
   logic            reset;
   logic [4:0]      id_rs1, id_rs2, ex_rd;
   logic            id_uses_rs2, id_halt, ex_memread, ex_redirect;
   logic            pc_write, ifid_write, ifid_flush, idex_flush, halted;
   logic [CntW-1:0] stall_cnt, flush_cnt;

   int checks   = 0;
   int failures = 0;

   // Model: cycle index, cycle HALT was accepted (-1 = none), event counts.
   int cyc      = 0;
   int halt_acc = -1;
   int m_stall  = 0;
   int m_flush  = 0;

   hazard_sequencer #(
      .DRAIN_CYCLES(DrainCycles),
      .CNT_W       (CntW)
   ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .id_uses_rs2(id_uses_rs2),
      .id_halt    (id_halt),
      .ex_memread (ex_memread),
      .ex_rd      (ex_rd),
      .ex_redirect(ex_redirect),
      .pc_write   (pc_write),
      .ifid_write (ifid_write),
      .ifid_flush (ifid_flush),
      .idex_flush (idex_flush),
      .halted     (halted),
      .stall_cnt  (stall_cnt),
      .flush_cnt  (flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic drive(input int rs1, input int rs2, input bit uses, input bit halt,
                        input bit memrd, input int rd, input bit redir);
      id_rs1      = 5'(rs1);
      id_rs2      = 5'(rs2);
      id_uses_rs2 = uses;
      id_halt     = halt;
      ex_memread  = memrd;
      ex_rd       = 5'(rd);
      ex_redirect = redir;
   endtask

   task automatic idle();
      drive(1, 2, 1'b0, 1'b0, 1'b0, 0, 1'b0);
   endtask

   // Compare every output with the model for the current cycle, then advance the model.
   task automatic check_now(input string tag);
      bit lu, running, e_halt;
      bit e_pc, e_ifw, e_iff, e_idf;
      lu = ex_memread && (ex_rd != 0) &&
           ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
      running = (halt_acc < 0);
      e_halt  = (halt_acc >= 0) && (cyc >= halt_acc + int'(DrainCycles));
      if (!reset) begin
         {e_pc, e_ifw, e_iff, e_idf} = 4'b0011;
         e_halt = 1'b0;
      end else if (!running)   {e_pc, e_ifw, e_iff, e_idf} = 4'b0011;
      else if (ex_redirect)    {e_pc, e_ifw, e_iff, e_idf} = 4'b1111;
      else if (lu)             {e_pc, e_ifw, e_iff, e_idf} = 4'b0001;
      else if (id_halt)        {e_pc, e_ifw, e_iff, e_idf} = 4'b0000;
      else                     {e_pc, e_ifw, e_iff, e_idf} = 4'b1100;

      check({tag, ".pc_write"},   32'(pc_write),   32'(e_pc));
      check({tag, ".ifid_write"}, 32'(ifid_write), 32'(e_ifw));
      check({tag, ".ifid_flush"}, 32'(ifid_flush), 32'(e_iff));
      check({tag, ".idex_flush"}, 32'(idex_flush), 32'(e_idf));
      check({tag, ".halted"},     32'(halted),     32'(e_halt));
      check({tag, ".stall_cnt"},  32'(stall_cnt),  32'(m_stall));
      check({tag, ".flush_cnt"},  32'(flush_cnt),  32'(m_flush));

      if (reset && running) begin
         if (ex_redirect)  m_flush  = (m_flush < CntMax) ? m_flush + 1 : CntMax;
         else if (lu)      m_stall  = (m_stall < CntMax) ? m_stall + 1 : CntMax;
         else if (id_halt) halt_acc = cyc;
      end
      cyc++;
   endtask

   // One clock: inputs were driven just after the rising edge; sample on the falling edge.
   task automatic cycle(input string tag);
      @(negedge clk);
      check_now(tag);
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset pulse applied between clock edges.
   task automatic do_reset(input string tag);
      reset = 1'b0;
      #1;
      halt_acc = -1;
      m_stall  = 0;
      m_flush  = 0;
      check_now(tag);
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      idle();
      #3;
      check_now("rst_init");
      @(posedge clk);
      #1;
      reset = 1'b1;
      cycle("idle");

      // Load-use on rs1, then the bubble drops ex_memread.
      drive(5, 0, 1'b0, 1'b0, 1'b1, 5, 1'b0); cycle("lu_rs1");
      idle();                                 cycle("lu_after");
      // x0 never stalls.
      drive(0, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0); cycle("lu_x0");
      // rs2 only matters when the instruction reads it.
      drive(1, 7, 1'b0, 1'b0, 1'b1, 7, 1'b0); cycle("rs2_unused");
      drive(1, 7, 1'b1, 1'b0, 1'b1, 7, 1'b0); cycle("rs2_used");
      idle();                                 cycle("rs2_after");

      // Redirect beats load-use.
      do_reset("rst_redir");
      drive(5, 0, 1'b0, 1'b0, 1'b1, 5, 1'b1); cycle("redir_lu");
      idle();                                 cycle("redir_after");

      // Halt drain with redirect pulses ignored.
      drive(1, 2, 1'b0, 1'b1, 1'b0, 0, 1'b0); cycle("halt_acc");
      for (int i = 0; i < 6; i++) begin
         drive(3, 3, 1'b1, 1'b1, 1'b1, 3, i[0]);
         cycle("drain");
      end
      do_reset("rst_halted");

      // Halt under redirect stays in RUN.
      drive(1, 2, 1'b0, 1'b1, 1'b0, 0, 1'b1); cycle("halt_redir");
      idle();
      for (int i = 0; i < 5; i++) cycle("post_halt_redir");

      // Saturation: 5 stall events on a 2-bit counter.
      do_reset("rst_sat");
      for (int i = 0; i < 5; i++) begin
         drive(9, 0, 1'b0, 1'b0, 1'b1, 9, 1'b0); cycle("sat_stall");
         idle();                                 cycle("sat_gap");
      end

      // Reset one cycle into DRAIN.
      drive(1, 2, 1'b0, 1'b1, 1'b0, 0, 1'b0); cycle("halt2");
      idle();                                 cycle("drain2");
      do_reset("rst_mid_drain");
      cycle("run_after_rst");

      // Random traffic with periodic resets.
      for (int n = 0; n < 800; n++) begin
         if ((n % 60) == 59) begin
            do_reset("rst_rand");
         end else begin
            drive($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
            cycle("rand");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline hazard and halt sequencer for the 5-stage RISC-V core, sitting beside the main opcode decoder.
- Generates PC and IF/ID write enables and the IF/ID and ID/EX flushes for three cases: load-use stalls, taken branch/jump redirects, and HALT.
- On HALT, drains in-flight instructions before asserting halted.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- DRAIN_CYCLES, 3: cycles after HALT leaves ID before halted asserts (EX, MEM, WB).
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs1  in  5  rs1 field of the instruction in ID.
- id_rs2  in  5  rs2 field of the instruction in ID.
- id_uses_rs2  in  1  ID instruction reads rs2 (R-type, store, branch).
- id_halt  in  1  decoder Halt for the instruction in ID.
- ex_memread  in  1  MemRead of the instruction in EX.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_redirect  in  1  branch taken, or JAL/JALR resolved in EX.
- pc_write  out  1  PC register load enable.
- ifid_write  out  1  IF/ID register load enable.
- ifid_flush  out  1  zero the IF/ID register.
- idex_flush  out  1  insert a bubble into ID/EX (all control fields 0).
- halted  out  1  core is stopped.
- stall_cnt  out  CNT_W  load-use stall cycles.
- flush_cnt  out  CNT_W  redirect events.

Behaviour:
- FSM states: RUN, DRAIN, HALTED. Reset state is RUN; drain counter 0; stall_cnt 0; flush_cnt 0.
- While reset is low, outputs are forced: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, halted=0.
- Hazard terms (combinational, same cycle):
  - lu = ex_memread & (ex_rd!=0) & ((ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
  - x0 never creates a hazard.
- RUN, priority order:
  - ex_redirect:
    - pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1.
    - lu and id_halt are ignored, since the ID instruction is wrong-path.
    - flush_cnt increments.
  - else lu:
    - pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=1 (one bubble).
    - stall_cnt increments.
    - The bubble clears ex_memread next cycle, so a stall lasts exactly 1 cycle.
  - else id_halt:
    - pc_write=0, ifid_write=0, idex_flush=0, so HALT advances to EX.
    - Next state DRAIN; drain counter loads DRAIN_CYCLES-1.
  - else: pc_write=1, ifid_write=1, both flushes 0.
- DRAIN:
  - pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1.
  - All hazard inputs are ignored; counters hold.
  - Drain counter decrements each cycle; when it is 0, next state is HALTED.
  - halted asserts exactly DRAIN_CYCLES cycles after the cycle where id_halt was accepted.
- HALTED:
  - Same enables and flushes as DRAIN; halted=1.
  - Leaves only on reset.
- Counters saturate at 2^CNT_W-1 with no wrap, and are updated only in RUN.
- halted is registered (decoded from state); all other control outputs are combinational from state and inputs.
- If reset asserts mid-DRAIN or while HALTED: immediate return to RUN, counters cleared, halted=0 asynchronously.
- DRAIN_CYCLES=1 is legal: HALTED is entered on the cycle after acceptance. DRAIN_CYCLES=0 is illegal (elaboration assertion).

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_rs1=5 for 1 cycle, then ex_memread=0 -> pc_write=0, ifid_write=0, idex_flush=1 for exactly 1 cycle; stall_cnt=1. Repeat with ex_rd=0 -> no stall.
- rs2 qualification: ex_rd=7, id_rs2=7, id_uses_rs2=0 -> no stall. Same with id_uses_rs2=1 -> 1-cycle stall.
- Redirect beats load-use: ex_redirect=1 together with the lu condition true -> pc_write=1, ifid_flush=1, idex_flush=1; flush_cnt=1, stall_cnt unchanged at 0.
- Halt drain (DRAIN_CYCLES=3): id_halt=1 at cycle N -> halted=1 from cycle N+3 onward; pc_write=0 from cycle N; ex_redirect pulses during DRAIN leave flush_cnt unchanged.
- Halt under redirect: id_halt=1 and ex_redirect=1 in the same cycle -> stays in RUN, halted never asserts, flush_cnt increments.
- Saturation and reset (CNT_W=2): 5 stall events -> stall_cnt=3. Then a halt, with reset pulled low one cycle into DRAIN -> halted=0, counters 0, and after release the outputs show RUN behaviour (pc_write=1).
